fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0200, the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single rising-edge clock.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port update_pc  input  1  redirect request from the hazard unit.
REQ-005 SHALL have port update_addr  input  32 (word_t)  redirect target.
REQ-006 SHALL have port flush  input  1  invalidates the fetch/decode register from the hazard unit.
REQ-007 SHALL have port stall  input  1  freezes the fetch/decode register from the hazard unit.
REQ-008 SHALL have port imem_ren  output  1  instruction read request.
REQ-009 SHALL have port imem_addr  output  32  instruction read address, word aligned.
REQ-010 SHALL have port imem_rdata  input  32  read data, valid in any cycle with imem_ren=1 and imem_busy=0.
REQ-011 SHALL have port imem_busy  input  1  memory wait; imem_addr stays stable while high.
REQ-012 SHALL have port fd_valid  output  1  fetch/decode register holds a live instruction.
REQ-013 SHALL have ports fd_instr and fd_pc  output  32 each  registered instruction and its PC.
REQ-014 SHALL have port fd_pc4  output  32  fd_pc+4, combinational.

Function
REQ-015 SHALL implement the FSM states RUN, HOLD and DRAIN, plus the registers pc, buf_instr and drain_addr.
REQ-016 In RUN, imem_ren=1 and imem_addr=pc.
REQ-017 In RUN, update_pc=1 -> pc<={update_addr[31:2],2'b00}; if imem_busy=1 -> drain_addr<=old pc, go to DRAIN; otherwise stay in RUN and discard any returned data.
REQ-018 In RUN, with update_pc=0, imem_busy=0 and stall=0 -> fd<={1,imem_rdata,pc} and pc<=pc+4.
REQ-019 In RUN, with update_pc=0, imem_busy=0 and stall=1 -> buf_instr<=imem_rdata, go to HOLD; pc and fd are unchanged.
REQ-020 In RUN, with imem_busy=1 and update_pc=0 -> pc and state hold.
REQ-021 In HOLD, imem_ren=0.
REQ-022 In HOLD, update_pc=1 -> pc<=aligned target, drop the buffer, go to RUN.
REQ-023 In HOLD, flush=1 with update_pc=0 -> drop the buffer, pc unchanged, go to RUN (refetch).
REQ-024 In HOLD, stall=0 with no flush or update_pc -> fd<={1,buf_instr,pc}, pc<=pc+4, go to RUN.
REQ-025 In DRAIN, imem_ren=1 and imem_addr=drain_addr; imem_busy=0 -> discard the data, go to RUN.
REQ-026 In DRAIN, update_pc=1 -> pc<=aligned target and the state stays DRAIN.
REQ-027 fd register priority is flush, then stall, then load: flush=1 -> fd_valid<=0 regardless of stall; stall=1 -> fd holds; otherwise load per REQ-018/REQ-024, else fd_valid<=0 (bubble).
REQ-028 A redirect cycle (update_pc=1) SHALL never load fd with valid=1.
REQ-029 pc+4 SHALL wrap mod 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-030 fd_instr and fd_pc SHALL hold their value when fd_valid<=0 is written by a flush or bubble; only fd_valid changes.
REQ-031 update_pc=1 together with stall=1 SHALL redirect pc; the redirect is never blocked by stall.

Reset
REQ-032 RST=1 at a clock edge -> pc=RESET_PC, state=RUN, fd_valid=0, fd_instr=0, fd_pc=0, buf_instr=0, drain_addr=0.
REQ-033 While RST=1, imem_ren=0.
REQ-034 Reset SHALL take precedence over every other input, including mid-DRAIN and mid-HOLD.
REQ-035 The first read request SHALL issue in the cycle after RST falls, at RESET_PC.

Verification
REQ-036 Straight-line fetch: zero-wait memory returning 0x13 for 4 cycles -> fd_pc goes 0x200, 0x204, 0x208, 0x20C with fd_valid=1 each cycle.
REQ-037 Stall capture: stall=1 for 3 cycles at pc 0x204 -> HOLD, imem_ren=0, fd keeps 0x200; stall released -> fd_pc=0x204, next request at 0x208.
REQ-038 Redirect during wait: imem_busy=1 at pc 0x208 and update_pc=1 with update_addr=0x1003 -> DRAIN with imem_addr held at 0x208 until busy=0; then fetch at 0x1000; the 0x208 data never appears in fd.
REQ-039 Flush+stall together -> fd_valid=0 the next cycle; fd_pc is unchanged.
REQ-040 Wrap: update_addr=0xFFFF_FFFC, zero wait -> fd_pc 0xFFFF_FFFC, then 0x0000_0000.
REQ-041 Reset mid-HOLD: RST=1 for 1 cycle -> pc=0x200, fd_valid=0, state RUN, imem_ren=1 in the following cycle.

Source files
------------

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Program counter and fetch/decode register with a one-entry
//               stall buffer and a drain state for redirects under memory wait.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        update_pc,
    input  logic [31:0] update_addr,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busy,
    output logic        fd_valid,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_pc4
);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_HOLD  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_drain_addr;
    logic        r_fd_valid;
    logic [31:0] r_fd_instr;
    logic [31:0] r_fd_pc;

    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic        w_run_take;
    logic        w_hold_take;
    logic        w_load;
    logic [31:0] w_load_instr;
    logic        w_unused_addr_bits;

    assign w_target           = {update_addr[31:2], 2'b00};
    assign w_pc_next          = r_pc + 32'd4;
    assign w_unused_addr_bits = ^update_addr[1:0];

    // An instruction enters fd only from a completed RUN read or from the
    // HOLD buffer, and never in a redirect cycle.
    assign w_run_take   = (r_state == c_RUN)  && !update_pc && !imem_busy && !stall;
    assign w_hold_take  = (r_state == c_HOLD) && !update_pc && !flush && !stall;
    assign w_load       = w_run_take || w_hold_take;
    assign w_load_instr = (r_state == c_HOLD) ? r_buf_instr : imem_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= c_RUN;
            r_pc         <= RESET_PC;
            r_buf_instr  <= 32'd0;
            r_drain_addr <= 32'd0;
            r_fd_valid   <= 1'b0;
            r_fd_instr   <= 32'd0;
            r_fd_pc      <= 32'd0;
        end else begin
            // Payload is only written on a real load; flush and bubbles clear valid alone.
            if (flush) begin
                r_fd_valid <= 1'b0;
            end else if (!stall) begin
                if (w_load) begin
                    r_fd_valid <= 1'b1;
                    r_fd_instr <= w_load_instr;
                    r_fd_pc    <= r_pc;
                end else begin
                    r_fd_valid <= 1'b0;
                end
            end

            case (r_state)
                c_RUN: begin
                    if (update_pc) begin
                        r_pc <= w_target;
                        if (imem_busy) begin
                            // The outstanding read must complete at its original address.
                            r_drain_addr <= r_pc;
                            r_state      <= c_DRAIN;
                        end
                    end else if (!imem_busy) begin
                        if (stall) begin
                            r_buf_instr <= imem_rdata;
                            r_state     <= c_HOLD;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end
                end
                c_HOLD: begin
                    if (update_pc) begin
                        r_pc    <= w_target;
                        r_state <= c_RUN;
                    end else if (flush) begin
                        r_state <= c_RUN;
                    end else if (!stall) begin
                        r_pc    <= w_pc_next;
                        r_state <= c_RUN;
                    end
                end
                c_DRAIN: begin
                    if (update_pc) begin
                        r_pc <= w_target;
                    end else if (!imem_busy) begin
                        r_state <= c_RUN;
                    end
                end
                default: begin
                    r_state <= c_RUN;
                end
            endcase
        end
    end

    assign imem_ren  = !RST && (r_state != c_HOLD);
    assign imem_addr = (r_state == c_DRAIN) ? r_drain_addr : r_pc;
    assign fd_valid  = r_fd_valid;
    assign fd_instr  = r_fd_instr;
    assign fd_pc     = r_fd_pc;
    assign fd_pc4    = r_fd_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed self-checking bench for fetch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        update_pc = 1'b0;
    logic [31:0] update_addr = 32'd0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busy = 1'b0;
    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc4;

    int          vectors = 0;
    int          fails   = 0;
    logic [31:0] mem_key = 32'h0000_0013;
    logic [31:0] exp_instr;

    // Memory returns address xor key so stale vs refetched data is visible.
    assign imem_rdata = imem_addr ^ mem_key;

    always #5 CLK = ~CLK;

    fetch_pc_unit #(.RESET_PC(32'h0000_0200)) dut (
        .CLK(CLK), .RST(RST), .update_pc(update_pc), .update_addr(update_addr),
        .flush(flush), .stall(stall), .imem_ren(imem_ren), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_busy(imem_busy), .fd_valid(fd_valid),
        .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_pc4(fd_pc4)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; update_pc = 1'b0; flush = 1'b0; stall = 1'b0; imem_busy = 1'b0;
        step();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(); step();
        vectors++; if (imem_ren !== 1'b0) begin fails++; $display("FAIL reset_ren got %b want 0", imem_ren); end
        vectors++; if (fd_valid !== 1'b0) begin fails++; $display("FAIL reset_fd_valid got %b want 0", fd_valid); end
        vectors++; if (fd_pc !== 32'd0) begin fails++; $display("FAIL reset_fd_pc got %h want 0", fd_pc); end
        vectors++; if (fd_instr !== 32'd0) begin fails++; $display("FAIL reset_fd_instr got %h want 0", fd_instr); end
        vectors++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL reset_addr got %h want 200", imem_addr); end
        vectors++; if (fd_pc4 !== 32'h4) begin fails++; $display("FAIL reset_fd_pc4 got %h want 4", fd_pc4); end
        RST = 1'b0;
        #1;
        vectors++; if (imem_ren !== 1'b1) begin fails++; $display("FAIL first_ren got %b want 1", imem_ren); end
        vectors++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL first_addr got %h want 200", imem_addr); end
    endtask

    task automatic test_straight();
        logic [31:0] p;
        for (int i = 0; i < 4; i++) begin
            p = 32'h200 + 32'(4 * i);
            step();
            vectors++; if (fd_valid !== 1'b1) begin fails++; $display("FAIL straight_valid[%0d] got %b want 1", i, fd_valid); end
            vectors++; if (fd_pc !== p) begin fails++; $display("FAIL straight_pc[%0d] got %h want %h", i, fd_pc, p); end
            exp_instr = p ^ 32'h13;
            vectors++; if (fd_instr !== exp_instr) begin fails++; $display("FAIL straight_instr[%0d] got %h want %h", i, fd_instr, exp_instr); end
        end
        vectors++; if (fd_pc4 !== 32'h210) begin fails++; $display("FAIL straight_pc4 got %h want 210", fd_pc4); end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (imem_ren !== 1'b0) begin fails++; $display("FAIL hold_ren[%0d] got %b want 0", i, imem_ren); end
            vectors++; if (fd_pc !== 32'h200 || fd_valid !== 1'b1) begin fails++; $display("FAIL hold_fd[%0d] got %h/%b want 200/1", i, fd_pc, fd_valid); end
            mem_key = 32'h5A00_0000;
        end
        stall = 1'b0;
        step();
        exp_instr = 32'h204 ^ 32'h13;
        vectors++; if (fd_pc !== 32'h204 || fd_valid !== 1'b1) begin fails++; $display("FAIL release_fd got %h/%b want 204/1", fd_pc, fd_valid); end
        vectors++; if (fd_instr !== exp_instr) begin fails++; $display("FAIL release_instr got %h want %h", fd_instr, exp_instr); end
        vectors++; if (imem_ren !== 1'b1 || imem_addr !== 32'h208) begin fails++; $display("FAIL release_next got %b/%h want 1/208", imem_ren, imem_addr); end
    endtask

    task automatic test_redirect_busy();
        imem_busy = 1'b1; update_pc = 1'b1; update_addr = 32'h1003;
        step();
        update_pc = 1'b0;
        vectors++; if (fd_valid !== 1'b0 || fd_pc !== 32'h204) begin fails++; $display("FAIL drain_fd got %b/%h want 0/204", fd_valid, fd_pc); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_ren !== 1'b1 || imem_addr !== 32'h208) begin fails++; $display("FAIL drain_addr[%0d] got %b/%h want 1/208", i, imem_ren, imem_addr); end
            if (i < 2) step();
        end
        imem_busy = 1'b0;
        step();
        vectors++; if (fd_valid !== 1'b0) begin fails++; $display("FAIL drain_discard got %b want 0", fd_valid); end
        vectors++; if (imem_addr !== 32'h1000) begin fails++; $display("FAIL redirect_addr got %h want 1000", imem_addr); end
        step();
        exp_instr = 32'h1000 ^ 32'h5A00_0000;
        vectors++; if (fd_pc !== 32'h1000 || fd_instr !== exp_instr || fd_valid !== 1'b1) begin fails++; $display("FAIL redirect_fd got %h/%h/%b want 1000/%h/1", fd_pc, fd_instr, fd_valid, exp_instr); end
        vectors++; if (fd_pc4 !== 32'h1004) begin fails++; $display("FAIL redirect_pc4 got %h want 1004", fd_pc4); end
        imem_busy = 1'b1;
        step();
        vectors++; if (fd_valid !== 1'b0 || imem_addr !== 32'h1004 || fd_pc !== 32'h1000) begin fails++; $display("FAIL busy_hold got %b/%h/%h want 0/1004/1000", fd_valid, imem_addr, fd_pc); end
        imem_busy = 1'b0;
        step();
    endtask

    task automatic test_flush_stall();
        vectors++; if (fd_pc !== 32'h1004 || fd_valid !== 1'b1) begin fails++; $display("FAIL pre_flush got %h/%b want 1004/1", fd_pc, fd_valid); end
        flush = 1'b1; stall = 1'b1;
        step();
        vectors++; if (fd_valid !== 1'b0 || fd_pc !== 32'h1004) begin fails++; $display("FAIL flush_stall got %b/%h want 0/1004", fd_valid, fd_pc); end
        stall = 1'b0;
        mem_key = 32'h00C0_0000;
        step();
        flush = 1'b0;
        vectors++; if (imem_ren !== 1'b1 || imem_addr !== 32'h1008) begin fails++; $display("FAIL hold_flush got %b/%h want 1/1008", imem_ren, imem_addr); end
        step();
        exp_instr = 32'h1008 ^ 32'h00C0_0000;
        vectors++; if (fd_pc !== 32'h1008 || fd_instr !== exp_instr || fd_valid !== 1'b1) begin fails++; $display("FAIL refetch got %h/%h/%b want 1008/%h/1", fd_pc, fd_instr, fd_valid, exp_instr); end
    endtask

    task automatic test_redirect_stall();
        update_pc = 1'b1; update_addr = 32'h3000; stall = 1'b1;
        step();
        update_pc = 1'b0; stall = 1'b0;
        vectors++; if (imem_addr !== 32'h3000 || imem_ren !== 1'b1) begin fails++; $display("FAIL redir_stall_addr got %b/%h want 1/3000", imem_ren, imem_addr); end
        vectors++; if (fd_pc !== 32'h1008 || fd_valid !== 1'b1) begin fails++; $display("FAIL redir_stall_fd got %h/%b want 1008/1", fd_pc, fd_valid); end
        step();
        vectors++; if (fd_pc !== 32'h3000 || fd_valid !== 1'b1) begin fails++; $display("FAIL redir_stall_next got %h/%b want 3000/1", fd_pc, fd_valid); end
    endtask

    task automatic test_wrap();
        update_pc = 1'b1; update_addr = 32'hFFFF_FFFC;
        step();
        update_pc = 1'b0;
        vectors++; if (fd_valid !== 1'b0) begin fails++; $display("FAIL redirect_bubble got %b want 0", fd_valid); end
        step();
        vectors++; if (fd_pc !== 32'hFFFF_FFFC || fd_valid !== 1'b1) begin fails++; $display("FAIL wrap_fd got %h/%b want fffffffc/1", fd_pc, fd_valid); end
        vectors++; if (fd_pc4 !== 32'h0 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next got %h/%h want 0/0", fd_pc4, imem_addr); end
        step();
        vectors++; if (fd_pc !== 32'h0 || fd_valid !== 1'b1) begin fails++; $display("FAIL wrap_zero got %h/%b want 0/1", fd_pc, fd_valid); end
    endtask

    task automatic test_reset_hold();
        stall = 1'b1;
        step();
        update_pc = 1'b1; update_addr = 32'h4009;
        step();
        update_pc = 1'b0;
        vectors++; if (imem_ren !== 1'b1 || imem_addr !== 32'h4008) begin fails++; $display("FAIL hold_redirect got %b/%h want 1/4008", imem_ren, imem_addr); end
        step();
        vectors++; if (imem_ren !== 1'b0) begin fails++; $display("FAIL rehold_ren got %b want 0", imem_ren); end
        RST = 1'b1;
        step();
        vectors++; if (fd_valid !== 1'b0 || fd_pc !== 32'h0 || imem_ren !== 1'b0) begin fails++; $display("FAIL rst_hold got %b/%h/%b want 0/0/0", fd_valid, fd_pc, imem_ren); end
        RST = 1'b0; stall = 1'b0;
        #1;
        vectors++; if (imem_ren !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL rst_hold_ren got %b/%h want 1/200", imem_ren, imem_addr); end
        step();
        vectors++; if (fd_pc !== 32'h200 || fd_valid !== 1'b1) begin fails++; $display("FAIL rst_hold_fetch got %h/%b want 200/1", fd_pc, fd_valid); end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall();
        test_redirect_busy();
        test_flush_stall();
        test_redirect_stall();
        test_wrap();
        test_reset_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
